load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the byte-addressed, big-endian 64-bit data memory.
- Accepts LDUR/STUR-family requests over a valid/ready handshake.
- Issues doubleword-aligned memory accesses.
- Extracts and sign/zero-extends sub-word loads.
- Performs read-modify-write for sub-word stores.
- Returns one response per request.

Parameters:
- MEMSIZE, 256, data memory size in bytes; must be a multiple of 8.
- WORDSIZE, 64, data width in bits; fixed for LEGv8.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- req_signed  in  1  sign-extend the load result; ignored for stores.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  64  load result; 0 for stores.
- resp_err  out  1  access was misaligned or out of range; no memory effect.
- mem_addr  out  64  doubleword-aligned address to the data memory.
- mem_rden  out  1  memory read enable.
- mem_wren  out  1  memory write enable.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data; combinational from mem_addr.

Behaviour:
- States: IDLE, RD, WR, RESP.
- Reset: state IDLE, all request and response registers cleared.
  - Reset values: req_ready=1; resp_valid=0, resp_data=0, resp_err=0; mem_rden=0, mem_wren=0, mem_addr=0, mem_wdata=0.
  - Reset is asynchronous, so mem_wren falls immediately even if asserted mid-WR. The write does not occur and no response is produced.
- req_ready=1 only in IDLE. A handshake (req_valid & req_ready at posedge) latches addr, size, signed, wr and wdata. Inputs outside a handshake are ignored.
- Offset o = addr[2:0]; aligned address A = {addr[63:3],3'b000}.
- Error condition: addr not naturally aligned for its size, or A > MEMSIZE-8.
  - On error: IDLE->RESP with resp_err=1, resp_data=0, and no mem_rden/mem_wren pulse.
- Transitions after handshake:
  - Load: IDLE->RD->RESP.
  - Doubleword store: IDLE->WR->RESP.
  - Sub-word store: IDLE->RD->WR->RESP.
- RD: mem_rden=1, mem_addr=A; mem_rdata is registered at the end of the cycle.
- WR: mem_wren=1 for exactly one cycle, mem_addr=A.
  - mem_wdata = req_wdata for a doubleword store.
  - Otherwise mem_wdata = the registered read word with lane bits [63-8o -: 8·bytes] replaced by the low 8·bytes of req_wdata.
- Load extraction uses the same big-endian lane. Zero- or sign-extend to 64 bits per req_signed; a doubleword load passes the word through unchanged.
- Latency, cycles from handshake edge to resp_valid:
  - Load 2.
  - Doubleword store 2.
  - Sub-word store 3.
  - Error 1.
- RESP: resp_valid=1; resp_data/resp_err are held stable until resp_valid & resp_ready, then go to IDLE.
  - A new request can be accepted in the cycle after the response handshake; there is no same-cycle overlap.
- mem_rden/mem_wren are 0 in every state except RD/WR respectively.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: misaligned accesses raise resp_err as above.
- Undefined: the offset is truncated to natural alignment (o &= ~(bytes-1)), misalignment never raises an error, and resp_err reflects only the out-of-range condition.

Decomposition:
- Shared header lsu.vh: size encodings (SZ_B, SZ_H, SZ_W, SZ_D), state encodings, lane-width helper constant. WORDSIZE/BYTESIZE come from the existing bus.vh.
- One natural combinational sub-module, lsu_lane:
  - inputs: offset, size, signed, word, wdata;
  - outputs: extracted/extended load value, merged store word.
- The FSM and registers stay in load_store_unit.

Test Plan:
- Memory word 0x10 = 0x0011223344556677. LDUR 0x10 -> resp_valid 2 cycles after handshake, resp_data 0x0011223344556677, resp_err 0.
- Word 0x18 = 0xFFEEDDCCBBAA9988.
  - LDURSW 0x1C (size 10, signed) -> 0xFFFFFFFFBBAA9988.
  - LDURH 0x1A unsigned -> 0x000000000000DDCC.
  - LDURB 0x19 signed -> 0xFFFFFFFFFFFFFFEE.
- STURB 0x11, wdata 0xAB -> RD, then mem_wren high exactly once with mem_wdata 0x00AB223344556677. resp_valid 3 cycles after handshake; subsequent LDUR 0x10 returns 0x00AB223344556677.
- LDURH 0x11 with LSU_ALIGN_CHECK_EN -> resp_err=1 one cycle after handshake, no rden/wren pulse. Without the macro -> resp_data 0x0011.
- Backpressure: complete a load with resp_ready=0 for 3 cycles. resp_valid/resp_data stay stable and req_ready=0; a request on the cycle after the accepting edge is taken.
- Reset low during WR of a STURH -> mem_wren drops combinationally, memory is unchanged, and after release req_ready=1 and resp_valid=0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: size and state encodings,
// the latched request payload and the lane-geometry helpers.
package load_store_unit_pkg;

    localparam int unsigned WORDSIZE = 64;
    localparam int unsigned BYTESIZE = 8;
    localparam int unsigned OFFW     = 3;   // byte offset within a doubleword
    localparam int unsigned SHW      = 6;   // bit-shift amount within a doubleword

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Request fields held from the handshake until the response retires.
    typedef struct packed {
        logic                wr;
        lsu_size_e           size;
        logic                is_signed;
        logic [OFFW-1:0]     offset;
        logic [WORDSIZE-1:0] wdata;
    } lsu_req_t;

    // bytes-1 for the access size; also the low-address alignment mask.
    function automatic logic [OFFW-1:0] size_mask(input lsu_size_e s);
        case (s)
            SZ_B:    return OFFW'(0);
            SZ_H:    return OFFW'(1);
            SZ_W:    return OFFW'(3);
            default: return OFFW'(7);
        endcase
    endfunction

    // WORDSIZE - 8*bytes: distance from the lane's MSB-justified position to bit 0.
    function automatic logic [SHW-1:0] lane_shift(input lsu_size_e s);
        case (s)
            SZ_B:    return SHW'(56);
            SZ_H:    return SHW'(48);
            SZ_W:    return SHW'(32);
            default: return SHW'(0);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the data-memory bus.
// master: MEM stage and data memory; slave: the load/store unit.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic                req_wr;
    logic [1:0]          req_size;
    logic                req_signed;
    logic [WORDSIZE-1:0] req_addr;
    logic [WORDSIZE-1:0] req_wdata;

    logic                resp_valid;
    logic                resp_ready;
    logic [WORDSIZE-1:0] resp_data;
    logic                resp_err;

    logic [WORDSIZE-1:0] mem_addr;
    logic                mem_rden;
    logic                mem_wren;
    logic [WORDSIZE-1:0] mem_wdata;
    logic [WORDSIZE-1:0] mem_rdata;

    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  mem_addr, mem_rden, mem_wren, mem_wdata
    );

    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output mem_addr, mem_rden, mem_wren, mem_wdata
    );

endinterface

// File: rtl/load_store_unit_lane.sv
// Big-endian lane logic: extracts and extends a sub-word load from a
// doubleword and merges sub-word store data into a doubleword.
module load_store_unit_lane
    import load_store_unit_pkg::*;
(
    input  logic [OFFW-1:0]     offset_i,
    input  lsu_size_e           size_i,
    input  logic                signed_i,
    input  logic [WORDSIZE-1:0] word_i,
    input  logic [WORDSIZE-1:0] wdata_i,
    output logic [WORDSIZE-1:0] load_c_o,
    output logic [WORDSIZE-1:0] merge_c_o
);

    logic [SHW-1:0]      off_sh;
    logic [SHW-1:0]      top_sh;
    logic [WORDSIZE-1:0] lane_up;
    logic [WORDSIZE-1:0] mask;
    logic [WORDSIZE-1:0] ins;

    // Byte o is bits [63-8o -: 8]; shift the lane to the MSB, then back down.
    always_comb begin
        off_sh  = {offset_i, 3'b000};
        top_sh  = lane_shift(size_i);
        lane_up = word_i << off_sh;
        if (signed_i) begin
            load_c_o = WORDSIZE'($signed(lane_up) >>> top_sh);
        end else begin
            load_c_o = lane_up >> top_sh;
        end
        mask      = ({WORDSIZE{1'b1}} << top_sh) >> off_sh;
        ins       = (wdata_i << top_sh) >> off_sh;
        merge_c_o = (word_i & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a big-endian 64-bit data memory.
// Optional build macro LSU_ALIGN_CHECK_EN: when defined, misaligned accesses
// return resp_err; otherwise the offset is truncated to natural alignment.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEMSIZE = 256
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    lsu_state_e          state_q, state_d;
    lsu_req_t            req_q, req_d;

    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [WORDSIZE-1:0] resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic [WORDSIZE-1:0] mem_addr_q, mem_addr_d;
    logic                mem_rden_q, mem_rden_d;
    logic                mem_wren_q, mem_wren_d;
    logic [WORDSIZE-1:0] mem_wdata_q, mem_wdata_d;

    lsu_size_e           in_size;
    logic [OFFW-1:0]     in_mask;
    logic [OFFW-1:0]     in_off;
    logic [WORDSIZE-1:0] in_aligned;
    logic                align_err;
    logic                range_err;

    logic [WORDSIZE-1:0] load_c;
    logic [WORDSIZE-1:0] merge_c;

    // Lane extraction/merge works on the word currently returned by memory.
    load_store_unit_lane u_lane (
        .offset_i  (req_q.offset),
        .size_i    (req_q.size),
        .signed_i  (req_q.is_signed),
        .word_i    (bus.mem_rdata),
        .wdata_i   (req_q.wdata),
        .load_c_o  (load_c),
        .merge_c_o (merge_c)
    );

    // Decode the incoming request: effective offset, aligned address, errors.
    always_comb begin
        in_size    = lsu_size_e'(bus.req_size);
        in_mask    = size_mask(in_size);
        in_aligned = {bus.req_addr[WORDSIZE-1:OFFW], OFFW'(0)};
`ifdef LSU_ALIGN_CHECK_EN
        align_err  = |(bus.req_addr[OFFW-1:0] & in_mask);
        in_off     = bus.req_addr[OFFW-1:0];
`else
        align_err  = 1'b0;
        in_off     = bus.req_addr[OFFW-1:0] & ~in_mask;
`endif
        range_err  = in_aligned > WORDSIZE'(MEMSIZE - 8);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_rden_d   = 1'b0;
        mem_wren_d   = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    req_d.wr        = bus.req_wr;
                    req_d.size      = in_size;
                    req_d.is_signed = bus.req_signed;
                    req_d.offset    = in_off;
                    req_d.wdata     = bus.req_wdata;
                    req_ready_d     = 1'b0;
                    if (align_err || range_err) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        mem_addr_d = in_aligned;
                        if (bus.req_wr && in_size == SZ_D) begin
                            state_d     = ST_WR;
                            mem_wren_d  = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            state_d    = ST_RD;
                            mem_rden_d = 1'b1;
                        end
                    end
                end
            end
            ST_RD: begin
                if (req_q.wr) begin
                    state_d     = ST_WR;
                    mem_wren_d  = 1'b1;
                    mem_wdata_d = merge_c;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = load_c;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_data_d  = '0;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_data_d  = '0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_rden_q   <= 1'b0;
            mem_wren_q   <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_rden_q   <= mem_rden_d;
            mem_wren_q   <= mem_wren_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rden   = mem_rden_q;
    assign bus.mem_wren   = mem_wren_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-byte behavioural data memory.
module tb_load_store_unit;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   rden_cnt = 0;
    int   wren_cnt = 0;
    logic [63:0] last_wdata = '0;
    logic [63:0] mem [0:31];

    load_store_unit_if bus ();

    load_store_unit #(.MEMSIZE(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read port; writes land on the clock edge.
    assign bus.mem_rdata = (bus.mem_addr < 64'd256) ? mem[bus.mem_addr[7:3]] : 64'd0;

    always @(posedge clk) begin
        if (bus.mem_rden) rden_cnt = rden_cnt + 1;
        if (bus.mem_wren) begin
            wren_cnt   = wren_cnt + 1;
            last_wdata = bus.mem_wdata;
            mem[bus.mem_addr[7:3]] = bus.mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Called #1 after the handshake edge; lat counts edges from that edge.
    task automatic wait_resp(output int lat, output logic [63:0] data, output logic err);
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat = lat + 1;
        end
        data = bus.resp_data;
        err  = bus.resp_err;
    endtask

    task automatic run(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input int exp_lat, input logic [63:0] exp_data, input logic exp_err,
                       input int exp_rd, input int exp_wr);
        int          lat;
        logic [63:0] data;
        logic        err;
        int          rd0;
        int          wr0;
        rd0 = rden_cnt;
        wr0 = wren_cnt;
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(lat, data, err);
        @(posedge clk); #1;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " data"}, data, exp_data);
        check({tag, " err"}, 64'(err), 64'(exp_err));
        check({tag, " rden pulses"}, 64'(rden_cnt - rd0), 64'(exp_rd));
        check({tag, " wren pulses"}, 64'(wren_cnt - wr0), 64'(exp_wr));
        check({tag, " ready after"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        int          lat;
        logic [63:0] data;
        logic        err;
        int          wr0;

        for (int i = 0; i < 32; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
        mem[2] = 64'h0011_2233_4455_6677;
        mem[3] = 64'hFFEE_DDCC_BBAA_9988;

        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 64'(bus.req_ready), 64'd1);
        check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst resp_data", bus.resp_data, 64'd0);
        check("rst resp_err", 64'(bus.resp_err), 64'd0);
        check("rst mem_rden", 64'(bus.mem_rden), 64'd0);
        check("rst mem_wren", 64'(bus.mem_wren), 64'd0);
        check("rst mem_addr", bus.mem_addr, 64'd0);
        check("rst mem_wdata", bus.mem_wdata, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Loads
        run("LDUR 0x10",   1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 2, 64'h0011_2233_4455_6677, 1'b0, 1, 0);
        run("LDURSW 0x1C", 1'b0, 2'b10, 1'b1, 64'h1C, 64'd0, 2, 64'hFFFF_FFFF_BBAA_9988, 1'b0, 1, 0);
        run("LDURH 0x1A",  1'b0, 2'b01, 1'b0, 64'h1A, 64'd0, 2, 64'h0000_0000_0000_DDCC, 1'b0, 1, 0);
        run("LDURB 0x19s", 1'b0, 2'b00, 1'b1, 64'h19, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFEE, 1'b0, 1, 0);
        run("LDURB 0x19u", 1'b0, 2'b00, 1'b0, 64'h19, 64'd0, 2, 64'h0000_0000_0000_00EE, 1'b0, 1, 0);
        run("LDUR top",    1'b0, 2'b11, 1'b0, 64'hF8, 64'd0, 2, 64'h1F1F_1F1F_1F1F_1F1F, 1'b0, 1, 0);
        run("LDUR oob",    1'b0, 2'b11, 1'b0, 64'h100, 64'd0, 1, 64'd0, 1'b1, 0, 0);
        run("STUR oob",    1'b1, 2'b00, 1'b0, 64'h1000, 64'hFF, 1, 64'd0, 1'b1, 0, 0);
`ifdef LSU_ALIGN_CHECK_EN
        run("LDURH 0x11",  1'b0, 2'b01, 1'b0, 64'h11, 64'd0, 1, 64'd0, 1'b1, 0, 0);
`else
        run("LDURH 0x11",  1'b0, 2'b01, 1'b0, 64'h11, 64'd0, 2, 64'h0000_0000_0000_0011, 1'b0, 1, 0);
`endif

        // Stores
        run("STURB 0x11",  1'b1, 2'b00, 1'b0, 64'h11, 64'hAB, 3, 64'd0, 1'b0, 1, 1);
        check("STURB wdata", last_wdata, 64'h00AB_2233_4455_6677);
        run("LDUR 0x10 after", 1'b0, 2'b11, 1'b0, 64'h10, 64'd0, 2, 64'h00AB_2233_4455_6677, 1'b0, 1, 0);
        run("STURW 0x24",  1'b1, 2'b10, 1'b0, 64'h24, 64'h1111_2222_CAFE_BABE, 3, 64'd0, 1'b0, 1, 1);
        check("STURW wdata", last_wdata, 64'h0404_0404_CAFE_BABE);
        run("STUR 0x28",   1'b1, 2'b11, 1'b0, 64'h28, 64'hDEAD_BEEF_CAFE_F00D, 2, 64'd0, 1'b0, 0, 1);
        run("LDUR 0x28",   1'b0, 2'b11, 1'b1, 64'h28, 64'd0, 2, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1, 0);

        // Backpressure: response held while a follow-up request waits
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_wr     = 1'b0;
        bus.req_size   = 2'b11;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'h18;
        @(posedge clk); #1;
        bus.req_size   = 2'b00;
        bus.req_addr   = 64'h19;
        wait_resp(lat, data, err);
        check("bp latency", 64'(lat), 64'd2);
        check("bp data", data, 64'hFFEE_DDCC_BBAA_9988);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp hold valid", 64'(bus.resp_valid), 64'd1);
            check("bp hold data", bus.resp_data, 64'hFFEE_DDCC_BBAA_9988);
            check("bp hold ready", 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp released ready", 64'(bus.req_ready), 64'd1);
        check("bp released valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("bp next taken", 64'(bus.req_ready), 64'd0);
        wait_resp(lat, data, err);
        check("bp next latency", 64'(lat), 64'd2);
        check("bp next data", data, 64'h0000_0000_0000_00EE);
        @(posedge clk); #1;

        // Reset in the middle of a sub-word store's write cycle
        wr0 = wren_cnt;
        bus.req_valid  = 1'b1;
        bus.req_wr     = 1'b1;
        bus.req_size   = 2'b01;
        bus.req_signed = 1'b0;
        bus.req_addr   = 64'h30;
        bus.req_wdata  = 64'h1234;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstwr wren high", 64'(bus.mem_wren), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rstwr wren drop", 64'(bus.mem_wren), 64'd0);
        @(posedge clk); #1;
        check("rstwr mem", mem[6], 64'h0606_0606_0606_0606);
        check("rstwr no write", 64'(wren_cnt - wr0), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstwr req_ready", 64'(bus.req_ready), 64'd1);
        check("rstwr resp_valid", 64'(bus.resp_valid), 64'd0);
        run("LDUR 0x30",   1'b0, 2'b11, 1'b0, 64'h30, 64'd0, 2, 64'h0606_0606_0606_0606, 1'b0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
